// File: rtl/reg_file_sb.sv
// Register file with two registered read ports, one write port and a per-register
// busy scoreboard. Define RF_BYPASS_EN to enable same-cycle write-to-read forwarding.
module reg_file_sb #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic [DATA_W-1:0] rd_data_1,
    output logic [DATA_W-1:0] rd_data_2,
    output logic              rd_valid,
    output logic              busy_1,
    output logic              busy_2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr
);
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam bit HAS_ZERO = (ZERO_REG != 0);

    // Handshake: no backpressure. A posedge with rd_en=1 captures both ports;
    // data and rd_valid appear one cycle later and hold until the next capture.
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [DATA_W-1:0]   rd_data_1_q, rd_data_1_d;
    logic [DATA_W-1:0]   rd_data_2_q, rd_data_2_d;
    logic                rd_valid_q, rd_valid_d;
    logic                zero_1, zero_2, zero_wr;
    logic [DATA_W-1:0]   rd_val_1, rd_val_2;

    assign zero_1  = HAS_ZERO && (rd_addr_1 == '0);
    assign zero_2  = HAS_ZERO && (rd_addr_2 == '0);
    assign zero_wr = HAS_ZERO && (wr_addr == '0);

`ifdef RF_BYPASS_EN
    logic wr_hit_1, wr_hit_2, rsv_hit_1, rsv_hit_2;
    assign wr_hit_1  = wr_en && (wr_addr == rd_addr_1);
    assign wr_hit_2  = wr_en && (wr_addr == rd_addr_2);
    assign rsv_hit_1 = rsv_en && (rsv_addr == rd_addr_1);
    assign rsv_hit_2 = rsv_en && (rsv_addr == rd_addr_2);
`endif

    always_comb begin
        busy_1   = busy_q[rd_addr_1] & ~zero_1;
        busy_2   = busy_q[rd_addr_2] & ~zero_2;
        rd_val_1 = regs_q[rd_addr_1];
        rd_val_2 = regs_q[rd_addr_2];
`ifdef RF_BYPASS_EN
        // A retiring write releases the operand unless it is re-issued this cycle.
        if (wr_hit_1 && !rsv_hit_1) busy_1 = 1'b0;
        if (wr_hit_2 && !rsv_hit_2) busy_2 = 1'b0;
        if (wr_hit_1) rd_val_1 = wr_data;
        if (wr_hit_2) rd_val_2 = wr_data;
`endif
        if (zero_1) rd_val_1 = '0;
        if (zero_2) rd_val_2 = '0;
    end

    always_comb begin
        regs_d      = regs_q;
        busy_d      = busy_q;
        rd_data_1_d = rd_data_1_q;
        rd_data_2_d = rd_data_2_q;
        rd_valid_d  = rd_valid_q;
        if (wr_en && !zero_wr) regs_d[wr_addr] = wr_data;
        // Release before reserve so a newer producer issued this cycle wins.
        if (wr_en)  busy_d[wr_addr]  = 1'b0;
        if (rsv_en) busy_d[rsv_addr] = 1'b1;
        if (HAS_ZERO) busy_d[0] = 1'b0;
        if (rd_en) begin
            rd_data_1_d = rd_val_1;
            rd_data_2_d = rd_val_2;
            rd_valid_d  = ~busy_1 & ~busy_2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            busy_q      <= '0;
            rd_data_1_q <= '0;
            rd_data_2_q <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            busy_q      <= busy_d;
            rd_data_1_q <= rd_data_1_d;
            rd_data_2_q <= rd_data_2_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign rd_data_1 = rd_data_1_q;
    assign rd_data_2 = rd_data_2_q;
    assign rd_valid  = rd_valid_q;
endmodule
